// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the load/store writeback unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WB} lsu_state_t;

    localparam int LSU_DW      = 8;
    localparam int LSU_AW      = 8;
    localparam int LSU_RW      = 3;
    localparam int LSU_TIMEOUT = 15;

endpackage

// File: rtl/lsu_writeback.sv
// Single-outstanding load/store unit: issues one memory access, writes load data
// back into the register file, and aborts accesses the memory never acknowledges.
module lsu_writeback
    import lsu_pkg::*;
#(
    parameter int DW      = LSU_DW,
    parameter int AW      = LSU_AW,
    parameter int RW      = LSU_RW,
    parameter int TIMEOUT = LSU_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_is_load,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [RW-1:0] req_rd,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          regWrite,
    output logic [RW-1:0] writeReg,
    output logic [DW-1:0] writeData,
    output logic          store_done,
    output logic          err
);

    localparam int             WDW  = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] TMAX = WDW'(TIMEOUT - 1);

    lsu_state_t     state, state_d;
    logic [WDW-1:0] wd, wd_d;
    logic           is_load_q;
    logic           accept, capture, done_d, err_d;

    // Handshake and memory strobes come from state alone, so no input reaches an output combinationally.
    assign req_ready = (state == IDLE);
    assign mem_req   = (state == ACCESS);
    assign mem_we    = mem_req & ~is_load_q;
    assign regWrite  = (state == WB);

    always_comb begin
        state_d = state;
        wd_d    = wd;
        accept  = 1'b0;
        capture = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    wd_d    = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // An ack on the final watchdog cycle still completes the access.
                if (mem_ack) begin
                    if (is_load_q) begin
                        capture = 1'b1;
                        state_d = WB;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (wd == TMAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd + WDW'(1);
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wd         <= '0;
            is_load_q  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            writeReg   <= '0;
            writeData  <= '0;
            store_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            wd         <= wd_d;
            store_done <= done_d;
            err        <= err_d;
            if (accept) begin
                is_load_q <= req_is_load;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                if (req_is_load) writeReg <= req_rd;
            end
            if (capture) writeData <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_writeback.sv
// Randomized scoreboard bench for lsu_writeback: driver pushes expected completions,
// a negedge monitor pops and compares whenever the unit reports one.
module tb_lsu_writeback;

    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready, req_is_load = 1'b0;
    logic [7:0] req_addr = '0, req_wdata = '0;
    logic [2:0] req_rd = '0;
    logic       mem_req, mem_we, mem_ack = 1'b0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic       regWrite, store_done, err;
    logic [2:0] writeReg;
    logic [7:0] writeData;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;   // 0 load writeback, 1 store done, 2 timeout
        logic [2:0] rd;
        logic [7:0] data;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    lsu_writeback #(.DW(8), .AW(8), .RW(3), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .store_done(store_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (regWrite || store_done || err)) begin
            chk("event_onehot", $countones({regWrite, store_done, err}), 1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: actual regWrite=%0b store_done=%0b err=%0b required none",
                         regWrite, store_done, err);
            end else begin
                mon_e = q.pop_front();
                chk("event_kind", regWrite ? 0 : (store_done ? 1 : 2), mon_e.kind);
                if (mon_e.kind == 0) begin
                    chk("writeReg", writeReg, mon_e.rd);
                    chk("writeData", writeData, mon_e.data);
                end
            end
        end
    end

    task automatic reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_regWrite"}, regWrite, 0);
        chk({tag, "_store_done"}, store_done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_writeReg"}, writeReg, 0);
        chk({tag, "_writeData"}, writeData, 0);
    endtask

    // dly: wait cycles before ack; dly >= T means the memory never answers.
    task automatic do_op(input bit ld, input logic [7:0] a, input logic [7:0] wdat,
                         input logic [2:0] r, input int dly, input logic [7:0] rdat, input bit keep);
        int   n;
        int   busy;
        int   exp_busy;
        exp_t e;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("ready_wait", req_ready, 1);
        req_valid   = 1'b1;
        req_is_load = ld;
        req_addr    = a;
        req_wdata   = wdat;
        req_rd      = r;
        e.rd   = r;
        e.data = rdat;
        e.kind = (dly >= T) ? 2 : (ld ? 0 : 1);
        q.push_back(e);
        exp_busy = (dly >= T) ? T : ((ld ? 2 : 1) + dly);
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
        busy = 0;
        for (int i = 0; i < T; i++) begin
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, !ld);
            chk("mem_addr", mem_addr, a);
            if (!ld) chk("mem_wdata", mem_wdata, wdat);
            busy++;
            if (i == dly) begin
                mem_ack   = 1'b1;
                mem_rdata = rdat;
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                break;
            end
            @(posedge clk); #1;
        end
        while (!req_ready && busy < 100) begin
            busy++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", busy, exp_busy);
        chk("mem_req_after", mem_req, 0);
    endtask

    initial begin
        #12;
        reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(1, 8'h10, 8'h00, 3'd5, 0, 8'hA5, 0);
        do_op(0, 8'h20, 8'h3C, 3'd0, 4, 8'h00, 0);
        do_op(1, 8'h30, 8'h00, 3'd2, T, 8'h00, 0);
        do_op(1, 8'h40, 8'h00, 3'd3, 0, 8'h11, 0);
        do_op(1, 8'h50, 8'h00, 3'd4, T - 1, 8'h7E, 0);
        do_op(1, 8'h51, 8'h00, 3'd0, 1, 8'h01, 0);
        do_op(1, 8'h52, 8'h00, 3'd7, 2, 8'hFE, 0);

        // Reset while an access is in flight
        req_valid = 1'b1; req_is_load = 1'b1; req_addr = 8'h55; req_rd = 3'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_access_mem_req_before", mem_req, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        reset_vals("rst_access");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset during writeback
        req_valid = 1'b1; req_is_load = 1'b1; req_addr = 8'h66; req_rd = 3'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h99;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("rst_wb_regWrite_before", regWrite, 1);
        #1 rst_n = 1'b0;
        #1;
        reset_vals("rst_wb");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray acks while idle must do nothing
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1; mem_rdata = 8'($urandom);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            chk("stray_ack_idle", {req_ready, mem_req, regWrite}, 3'b100);
        end

        // Back-to-back with req_valid held high across the store's completion
        do_op(0, 8'h60, 8'hC3, 3'd0, 0, 8'h00, 1);
        do_op(1, 8'h61, 8'h00, 3'd1, 0, 8'h5A, 0);

        for (int k = 0; k < 40; k++) begin
            int sel;
            int dly;
            sel = $urandom_range(0, 9);
            if (sel < 7)       dly = $urandom_range(0, 3);
            else if (sel == 7) dly = T - 1;
            else               dly = T;
            do_op(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), dly, 8'($urandom), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
